// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states,
// and the request legality check used when the array is accessed.
package data_mem_responder_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned, illegal size, or word index beyond the array.
  function automatic logic access_error(input logic [31:0] addr,
                                        input logic [1:0]  size,
                                        input int unsigned depth);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr[0];
      SIZE_WORD: bad = |addr[1:0];
      default:   bad = 1'b1;
    endcase
    return bad | ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Little-endian lane steering: merges store data into the old word and
// extracts/extends the addressed lane for loads. Purely combinational.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_val
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [31:0] w_byte_mask;
  logic [31:0] w_half_mask;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte_sh   = {i_addr_lo, 3'b000};
  assign w_half_sh   = {i_addr_lo[1], 4'b0000};
  assign w_byte_mask = 32'h0000_00FF << w_byte_sh;
  assign w_half_mask = 32'h0000_FFFF << w_half_sh;
  assign w_byte      = 8'(i_old_word >> w_byte_sh);
  assign w_half      = 16'(i_old_word >> w_half_sh);

  always_comb begin
    o_store_word = i_old_word;
    o_load_val   = '0;
    case (i_size)
      SIZE_BYTE: begin
        o_store_word = (i_old_word & ~w_byte_mask) | ({24'h0, i_wdata[7:0]} << w_byte_sh);
        o_load_val   = {{24{i_sign & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_store_word = (i_old_word & ~w_half_mask) | ({16'h0, i_wdata[15:0]} << w_half_sh);
        o_load_val   = {{16{i_sign & w_half[15]}}, w_half};
      end
      SIZE_WORD: begin
        o_store_word = i_wdata;
        o_load_val   = i_old_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder over a word array with a fixed
// number of wait states between accept and response.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_enter_resp;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [31:0] r_rdata;
  logic        r_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_acc_write;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [1:0]  w_acc_size;
  logic        w_acc_sign;
  logic        w_acc_err;
  logic [AW-1:0] w_idx;
  logic [31:0] w_old_word;
  logic [31:0] w_store_word;
  logic [31:0] w_load_val;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        // The edge that takes the counter to zero is the one entering RESP.
        if (r_cnt <= 4'd1) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
          w_cnt_nxt    = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
      r_sign  <= req_sign;
    end
  end

  // With zero wait states the access happens on the accept edge itself,
  // before the latched copy exists, so the live request is used instead.
  assign w_acc_write = (r_state == IDLE) ? req_write : r_write;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_acc_size  = (r_state == IDLE) ? req_size  : r_size;
  assign w_acc_sign  = (r_state == IDLE) ? req_sign  : r_sign;
  assign w_acc_err   = access_error(w_acc_addr, w_acc_size, DEPTH_WORDS);
  assign w_idx       = w_acc_addr[AW+1:2];
  assign w_old_word  = r_mem[w_idx];

  mem_lane_align u_lane (
    .i_old_word   (w_old_word),
    .i_addr_lo    (w_acc_addr[1:0]),
    .i_size       (w_acc_size),
    .i_sign       (w_acc_sign),
    .i_wdata      (w_acc_wdata),
    .o_store_word (w_store_word),
    .o_load_val   (w_load_val)
  );

  // Array is never reset; the reset term only blocks a commit racing reset.
  always_ff @(posedge clk) begin
    if (w_enter_resp && w_acc_write && !w_acc_err && !reset) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else if (w_enter_resp) begin
      r_error <= w_acc_err;
      r_rdata <= (w_acc_err || w_acc_write) ? 32'd0 : w_load_val;
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_error = r_error;

endmodule
